// File: rtl/accu_rr_sched.sv
// Round-robin front end for a shared 4-beat accumulator: grants one requester per
// group of GROUP_LEN beats, muxes its samples through, and tags returned sums.
module accu_rr_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 8,
  parameter int GROUP_LEN = 4,
  parameter int STALL_MAX = 16,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  acc_valid_o,
  output logic [DW-1:0]         acc_data_o,
  input  logic                  acc_res_valid,
  input  logic [DW+1:0]         acc_res_data,
  output logic                  res_valid,
  output logic [DW+1:0]         res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  stall_err
);

  localparam int BCW = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
  localparam int SCW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_owner;
  logic [IDW-1:0]   r_last_grant;
  logic [IDW-1:0]   r_pend_id;
  logic [BCW-1:0]   r_beat_cnt;
  logic [SCW-1:0]   r_stall_cnt;
  logic             r_stall_err;
  logic             r_res_valid;
  logic [DW+1:0]    r_res_data;
  logic [IDW-1:0]   r_res_id;

  logic             w_any;
  logic [IDW-1:0]   w_pick;
  logic             w_own_valid;
  logic [DW-1:0]    w_own_data;
  logic             w_beat;
  logic             w_last_beat;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                              input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % $unsigned(NUM_REQ);
    return s[IDW-1:0];
  endfunction

  // Search starts just after the last completed owner and wraps once.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last_grant;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_any && req_valid[wrap_idx(r_last_grant, k)]) begin
        w_any  = 1'b1;
        w_pick = wrap_idx(r_last_grant, k);
      end
    end
  end

  assign w_own_valid = req_valid[r_owner];
  assign w_own_data  = req_data[r_owner*DW +: DW];
  assign w_last_beat = w_beat && (r_beat_cnt == BCW'(GROUP_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    acc_valid_o = 1'b0;
    acc_data_o  = '0;
    w_beat      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = BURST;
      end
      BURST: begin
        req_ready[r_owner] = 1'b1;
        acc_valid_o        = w_own_valid;
        acc_data_o         = w_own_data;
        w_beat             = w_own_valid;
        if (w_beat && (r_beat_cnt == BCW'(GROUP_LEN - 1))) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= '0;
      r_beat_cnt   <= '0;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_pend_id    <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_owner    <= w_pick;
        r_beat_cnt <= '0;
      end
    end else if (w_beat) begin
      if (w_last_beat) begin
        r_beat_cnt   <= '0;
        r_last_grant <= r_owner;
        r_pend_id    <= r_owner;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  // Pulse registers on the STALL_MAX-th consecutive idle owner cycle; grant is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_stall_err <= 1'b0;
      if (r_state == BURST && !w_own_valid) begin
        if (r_stall_cnt == SCW'(STALL_MAX - 1)) begin
          r_stall_err <= 1'b1;
          r_stall_cnt <= '0;
        end else begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      r_res_valid <= acc_res_valid;
      if (acc_res_valid) begin
        r_res_data <= acc_res_data;
        r_res_id   <= r_pend_id;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign stall_err = r_stall_err;

endmodule
